// File: rtl/dfd_dst_pkg.sv
// dfd_dst_pkg: shared types and constants for the debug-signal-trace encoder
package dfd_dst_pkg;
  typedef enum logic [2:0] {
    FMT_NONE    = 3'd0,
    FMT_XOR     = 3'd1,
    FMT_VLT_XOR = 3'd3
  } dst_format_mode_e;
  localparam logic [1:0] TRACE_INFO_NONE  = 2'b00;
  localparam logic [1:0] TRACE_INFO_START = 2'b01;
  localparam logic [1:0] TRACE_INFO_STOP  = 2'b10;
  localparam logic [1:0] TRACE_INFO_SYNC  = 2'b11;
  localparam int LOST_CNT_WIDTH = 16;
  // Header is {byte_enable, pkt_type, source_id, packet_lost, trace_info[1:0]}
  function automatic int vlt_hdr_bytes(input int data_w, input int src_id_w = 4);
    return (data_w / 8 + src_id_w + 4) / 8;
  endfunction
endpackage

// File: rtl/dfd_dst_byte_compactor.sv
// dfd_dst_byte_compactor: packs the nonzero bytes of x toward byte 0
module dfd_dst_byte_compactor #(
  parameter int BE_W = 8,
  parameter int LEN_W = $clog2(BE_W + 1) + 1,
  localparam int DATA_W = 8 * BE_W
) (
  input  logic [DATA_W-1:0] x,
  output logic [BE_W-1:0]   byte_enable,
  output logic [DATA_W-1:0] packed_data,
  output logic [LEN_W-1:0]  popcount
);
  // Running count of enabled bytes gives each kept byte its output slot
  always_comb begin
    byte_enable = '0;
    packed_data = '0;
    popcount = '0;
    for (int i = 0; i < BE_W; i++) begin
      byte_enable[i] = |x[8*i +: 8];
      if (byte_enable[i]) packed_data[8*popcount +: 8] = x[8*i +: 8];
      popcount = popcount + LEN_W'(byte_enable[i]);
    end
  end
endmodule

// File: rtl/dfd_dst_vlt_encoder.sv
// dfd_dst_vlt_encoder: builds VLT trace packets from debug samples with start/stop/sync and loss tracking
module dfd_dst_vlt_encoder
  import dfd_dst_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SRC_ID_W = 4,
  parameter int SYNC_CTR_W = 20,
  localparam int BE_W = DATA_W / 8,
  localparam int HDR_W = BE_W + SRC_ID_W + 4,
  localparam int LEN_W = $clog2(BE_W + HDR_W / 8) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dbg_valid,
  input  logic [DATA_W-1:0]         dbg_data,
  input  logic                      cfg_enable,
  input  logic [2:0]                cfg_mode,
  input  logic [SRC_ID_W-1:0]       cfg_source_id,
  input  logic [SYNC_CTR_W-1:0]     cfg_sync_period,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [HDR_W-1:0]          out_hdr,
  output logic [DATA_W-1:0]         out_data,
  output logic [LEN_W-1:0]          out_len,
  output logic [LOST_CNT_WIDTH-1:0] lost_cnt
);
  localparam logic [LEN_W-1:0] HDR_LEN = LEN_W'(vlt_hdr_bytes(DATA_W, SRC_ID_W));
  localparam logic [LEN_W-1:0] FULL_LEN = HDR_LEN + LEN_W'(BE_W);
  logic en_q, start_pend_q, start_pend_d, stop_pend_q, stop_pend_d, lost_pend_q, lost_pend_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [SYNC_CTR_W-1:0] sync_ctr_q, sync_ctr_d;
  logic [LOST_CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;
  logic out_valid_q, out_valid_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic rise, fall, slot_free, accept, drop, start_now, load_stop, load, sync_due, full, vlt;
  logic [SYNC_CTR_W-1:0] ctr_eff;
  logic [DATA_W-1:0] x, packed_x;
  logic [BE_W-1:0] be_c;
  logic [LEN_W-1:0] pop;
  logic [1:0] ti;
  // An enable edge takes effect in the same cycle so a sample arriving with it becomes the start packet
  assign rise = cfg_enable && !en_q;
  assign fall = !cfg_enable && en_q;
  assign slot_free = !out_valid_q || out_ready;
  assign accept = dbg_valid && cfg_enable && slot_free && !stop_pend_q;
  assign drop = dbg_valid && cfg_enable && !slot_free;
  assign start_now = start_pend_q || rise;
  assign load_stop = (stop_pend_q || fall) && slot_free;
  assign load = load_stop || accept;
  assign ctr_eff = rise ? '0 : sync_ctr_q;
  assign sync_due = (cfg_sync_period != '0) && (ctr_eff >= cfg_sync_period - SYNC_CTR_W'(1));
  assign full = start_now || sync_due;
  assign x = dbg_data ^ (rise ? '0 : prev_q);
  dfd_dst_byte_compactor #(.BE_W(BE_W), .LEN_W(LEN_W)) u_compactor (
    .x(x),
    .byte_enable(be_c),
    .packed_data(packed_x),
    .popcount(pop)
  );
  // Select the packet to load: stop first, then the accepted sample as full or compressed
  always_comb begin
    ti = load_stop ? TRACE_INFO_STOP : start_now ? TRACE_INFO_START : sync_due ? TRACE_INFO_SYNC : TRACE_INFO_NONE;
    vlt = !load_stop && !full && (cfg_mode == FMT_VLT_XOR);
    hdr_d = {load_stop ? '0 : vlt ? be_c : {BE_W{1'b1}}, 1'b0, cfg_source_id, lost_pend_q, ti};
    data_d = load_stop ? '0 : full ? dbg_data : vlt ? packed_x : (cfg_mode == FMT_XOR) ? x : dbg_data;
    len_d = load_stop ? HDR_LEN : vlt ? HDR_LEN + pop : FULL_LEN;
  end
  // Next-state for pending flags, XOR reference, sync counter, loss counter and slot occupancy
  always_comb begin
    start_pend_d = !fall && !accept && start_now;
    stop_pend_d = !load_stop && (stop_pend_q || fall);
    lost_pend_d = drop || (lost_pend_q && !load);
    lost_cnt_d = lost_cnt_q + LOST_CNT_WIDTH'(drop && (lost_cnt_q != '1));
    prev_d = accept ? dbg_data : rise ? '0 : prev_q;
    sync_ctr_d = accept ? (full ? '0 : ctr_eff + SYNC_CTR_W'(ctr_eff != '1)) : ctr_eff;
    out_valid_d = load || (out_valid_q && !out_ready);
  end
  // State and output register stage; packet fields only change when a packet is loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
      start_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      lost_pend_q <= 1'b0;
      prev_q <= '0;
      sync_ctr_q <= '0;
      lost_cnt_q <= '0;
      out_valid_q <= 1'b0;
      hdr_q <= '0;
      data_q <= '0;
      len_q <= '0;
    end else begin
      en_q <= cfg_enable;
      start_pend_q <= start_pend_d;
      stop_pend_q <= stop_pend_d;
      lost_pend_q <= lost_pend_d;
      prev_q <= prev_d;
      sync_ctr_q <= sync_ctr_d;
      lost_cnt_q <= lost_cnt_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        hdr_q <= hdr_d;
        data_q <= data_d;
        len_q <= len_d;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign out_hdr = hdr_q;
  assign out_data = data_q;
  assign out_len = len_q;
  assign lost_cnt = lost_cnt_q;
endmodule
